// File: rtl/bcm_pkg.sv
// bcm_pkg - shared types and sizing helpers for the BCM plane sequencer.
//
// Contents:
//   bcm_state_e  - sequencer states IDLE/FETCH/SHOW/BLANK/DONE
//   *_DEF        - default BIT_DEPTH / ADDR_W / BASE_TICKS
//   plane_ticks  - on-time of bit-plane b, BASE_TICKS << b
//   cnt_width    - tick counter width, wide enough for the longest plane
//
// Optional feature macro used by the files importing this package:
//   BCM_GLOBAL_DIM_EN (global dimming via dim_shift).
package bcm_pkg;

    localparam int BIT_DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF     = 7;
    localparam int BASE_TICKS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHOW  = 3'd2,
        BLANK = 3'd3,
        DONE  = 3'd4
    } bcm_state_e;

    function automatic int plane_ticks(input int base, input int b);
        return base << b;
    endfunction

    function automatic int cnt_width(input int base, input int depth);
        return $clog2(base << (depth - 1)) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(BASE_TICKS_DEF, BIT_DEPTH_DEF);

endpackage

// File: rtl/bcm_plane_timer.sv
// bcm_plane_timer - loadable down-counter timing one bit-plane.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          reload the counter this edge (entry into SHOW)
//   load_value_i    plane length minus one
//   on_value_i      lit cycles for the plane (BCM_GLOBAL_DIM_EN only)
//   last_tick_o     counter has reached zero: final cycle of the plane
//   on_window_o     the cycle after this edge is inside the lit window
//                   (BCM_GLOBAL_DIM_EN only)
module bcm_plane_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
`ifdef BCM_GLOBAL_DIM_EN
    input  logic [CNT_W-1:0] on_value_i,
    output logic             on_window_o,
`endif
    output logic             last_tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at zero; it never wraps back to the top.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_value_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign last_tick_o = (cnt_q == '0);

`ifdef BCM_GLOBAL_DIM_EN
    // Remaining lit cycles, current cycle included. The window flag looks at
    // the next value because led_out is registered one edge ahead.
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;

    always_comb begin
        on_cnt_d = on_cnt_q;
        if (load_i)
            on_cnt_d = on_value_i;
        else if (on_cnt_q != '0)
            on_cnt_d = on_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) on_cnt_q <= '0;
        else        on_cnt_q <= on_cnt_d;
    end

    assign on_window_o = (on_cnt_d != '0);
`endif

endmodule

// File: rtl/bcm_plane_sequencer.sv
// bcm_plane_sequencer - binary-code-modulation engine feeding one LED from
// the brightness word at the address held by pointerRegister.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         level-sensitive run request
//   address        current pointer from pointerRegister
//   pixel_data     brightness word for address, sampled in FETCH
//   dim_shift      global dim, sampled in FETCH (BCM_GLOBAL_DIM_EN only)
//   led_out        registered BCM drive
//   operation_dn   one-cycle pulse in DONE, advances pointerRegister
//   plane_idx      bit-plane currently shown
//   cur_addr       address latched in FETCH
//   busy           high in every state but IDLE
//
// Every address takes FETCH + sum(plane times) + (BIT_DEPTH-1) BLANKs + DONE
// clocks regardless of pixel value.
// Optional feature macro: BCM_GLOBAL_DIM_EN.
module bcm_plane_sequencer
    import bcm_pkg::*;
#(
    parameter int BIT_DEPTH  = BIT_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int BASE_TICKS = BASE_TICKS_DEF,
    localparam int PW        = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    address,
    input  logic [BIT_DEPTH-1:0] pixel_data,
`ifdef BCM_GLOBAL_DIM_EN
    input  logic [1:0]           dim_shift,
`endif
    output logic                 led_out,
    output logic                 operation_dn,
    output logic [PW-1:0]        plane_idx,
    output logic [ADDR_W-1:0]    cur_addr,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(BASE_TICKS, BIT_DEPTH);

    bcm_state_e           state_q, state_d;
    logic [BIT_DEPTH-1:0] word_q, word_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [PW-1:0]        plane_q, plane_d;
    logic                 led_q, led_d, dn_q, dn_d, busy_q, busy_d;
    logic                 tmr_load, tmr_last, led_gate;
    logic [CNT_W-1:0]     tmr_load_val;

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = enable ? FETCH : IDLE;
            FETCH:   state_d = enable ? SHOW : IDLE;
            SHOW: begin
                if (!enable)
                    state_d = IDLE;
                else if (tmr_last)
                    state_d = (plane_q < PW'(BIT_DEPTH - 1)) ? BLANK : DONE;
            end
            BLANK:   state_d = enable ? SHOW : IDLE;
            DONE:    state_d = enable ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- datapath: word/address capture and plane stepping ----
    // The word is taken from pixel_data directly on the FETCH->SHOW edge so
    // plane 0 can be driven on that same edge.
    always_comb begin
        word_d = word_q;
        addr_d = addr_q;
        if (state_q == FETCH) begin
            word_d = pixel_data;
            addr_d = address;
        end
        if (state_d == IDLE || state_d == FETCH)
            plane_d = '0;
        else if (state_q == BLANK && state_d == SHOW)
            plane_d = plane_q + PW'(1);
        else
            plane_d = plane_q;
        tmr_load     = (state_d == SHOW) && (state_q != SHOW);
        tmr_load_val = CNT_W'(plane_ticks(BASE_TICKS, int'(plane_d)) - 1);
    end

`ifdef BCM_GLOBAL_DIM_EN
    logic [1:0]       dim_q, dim_d;
    logic [CNT_W-1:0] tmr_on_val;

    always_comb begin
        dim_d      = (state_q == FETCH) ? dim_shift : dim_q;
        tmr_on_val = CNT_W'(plane_ticks(BASE_TICKS, int'(plane_d)) >> dim_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dim_q <= '0;
        else        dim_q <= dim_d;
    end

    bcm_plane_timer #(.CNT_W(CNT_W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (tmr_load),
        .load_value_i (tmr_load_val),
        .on_value_i   (tmr_on_val),
        .on_window_o  (led_gate),
        .last_tick_o  (tmr_last)
    );
`else
    assign led_gate = 1'b1;

    bcm_plane_timer #(.CNT_W(CNT_W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (tmr_load),
        .load_value_i (tmr_load_val),
        .last_tick_o  (tmr_last)
    );
`endif

    // ---- output logic: registered outputs describe the state being entered ----
    always_comb begin
        led_d  = (state_d == SHOW) && word_d[plane_d] && led_gate;
        dn_d   = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            addr_q  <= '0;
            plane_q <= '0;
            led_q   <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            addr_q  <= addr_d;
            plane_q <= plane_d;
            led_q   <= led_d;
            dn_q    <= dn_d;
            busy_q  <= busy_d;
        end
    end

    assign led_out      = led_q;
    assign operation_dn = dn_q;
    assign plane_idx    = plane_q;
    assign cur_addr     = addr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bcm_plane_sequencer.sv
module tb_bcm_plane_sequencer;
    localparam int BD = 8, AW = 7, PERIOD = 1029, LIMIT = 2000;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [AW-1:0] address = '0;
    logic [BD-1:0] pixel_data = '0;
`ifdef BCM_GLOBAL_DIM_EN
    logic [1:0]    dim_shift = '0;
`endif
    logic          led_out, operation_dn, busy;
    logic [2:0]    plane_idx;
    logic [AW-1:0] cur_addr;

    bcm_plane_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .address      (address),
        .pixel_data   (pixel_data),
`ifdef BCM_GLOBAL_DIM_EN
        .dim_shift    (dim_shift),
`endif
        .led_out      (led_out),
        .operation_dn (operation_dn),
        .plane_idx    (plane_idx),
        .cur_addr     (cur_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] pix;
        logic [1:0] dim;
        int         exp_high;
        int         exp_run;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n, highs, run, maxrun, align, pmax, done_at, gap, dbl, found;
        logic [6:0] exp_a;

        // ---- reset held with enable high ----
        rst_n = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_led", led_out, 0);
        chk("rst_dn", operation_dn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_plane", plane_idx, 0);
        chk("rst_addr", cur_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 1);

        // ---- table-driven pixel patterns ----
        vecs.push_back('{pix: 8'h00, dim: 2'd0, exp_high: 0,    exp_run: 0});
        vecs.push_back('{pix: 8'h01, dim: 2'd0, exp_high: 4,    exp_run: 4});
        vecs.push_back('{pix: 8'hA5, dim: 2'd0, exp_high: 660,  exp_run: 512});
        vecs.push_back('{pix: 8'hFF, dim: 2'd0, exp_high: 1020, exp_run: 512});
`ifdef BCM_GLOBAL_DIM_EN
        vecs.push_back('{pix: 8'hFF, dim: 2'd1, exp_high: 510,  exp_run: 256});
        vecs.push_back('{pix: 8'hFF, dim: 2'd3, exp_high: 127,  exp_run: 64});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            rst_n = 1'b0; enable = 1'b0;
            @(negedge clk);
            pixel_data = v.pix;
`ifdef BCM_GLOBAL_DIM_EN
            dim_shift = v.dim;
`endif
            rst_n = 1'b1; enable = 1'b1;
            n = 0; highs = 0; run = 0; maxrun = 0; align = 0; pmax = 0; done_at = 0;
            while (n < LIMIT && done_at == 0) begin
                @(negedge clk);
                n++;
                if (n == 2) pixel_data = ~v.pix;  // must be ignored after FETCH
                if (led_out) begin
                    highs++; run++;
                    if (!v.pix[plane_idx]) align++;
                end else run = 0;
                if (run > maxrun) maxrun = run;
                if (int'(plane_idx) > pmax) pmax = int'(plane_idx);
                if (operation_dn) done_at = n;
            end
            pixel_data = v.pix;
            chk($sformatf("v%0d_done_at", i), done_at, PERIOD);
            chk($sformatf("v%0d_highs", i), highs, v.exp_high);
            chk($sformatf("v%0d_maxrun", i), maxrun, v.exp_run);
            chk($sformatf("v%0d_align", i), align, 0);
            chk($sformatf("v%0d_planemax", i), pmax, 7);
            // second period, back-to-back with enable held
            gap = 0; dbl = 0; found = 0; highs = 0;
            while (gap < LIMIT && found == 0) begin
                @(negedge clk);
                gap++;
                if (led_out) highs++;
                if (operation_dn) begin
                    if (gap == 1) dbl++;
                    else found = gap;
                end
            end
            chk($sformatf("v%0d_gap", i), found, PERIOD);
            chk($sformatf("v%0d_dbl", i), dbl, 0);
            chk($sformatf("v%0d_highs2", i), highs, v.exp_high);
        end
`ifdef BCM_GLOBAL_DIM_EN
        dim_shift = 2'd0;
`endif

        // ---- enable dropped during plane 4 SHOW ----
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk);
        pixel_data = 8'hFF; rst_n = 1'b1; enable = 1'b1;
        n = 0; found = 0;
        while (n < LIMIT && found == 0) begin
            @(negedge clk); n++;
            if (plane_idx == 3'd4 && led_out) found = 1;
        end
        chk("ab_reach_p4", found, 1);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_led", led_out, 0);
        chk("ab_dn", operation_dn, 0);
        dbl = 0;
        repeat (20) begin
            @(negedge clk);
            if (operation_dn || busy) dbl++;
        end
        chk("ab_quiet", dbl, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("re_busy", busy, 1);
        chk("re_led_fetch", led_out, 0);
        @(negedge clk);
        chk("re_plane0", plane_idx, 0);
        chk("re_led_p0", led_out, 1);

        // ---- enable dropped in DONE: pulse completes, then IDLE ----
        n = 0; found = 0;
        while (n < LIMIT && found == 0) begin
            @(negedge clk); n++;
            if (operation_dn) found = 1;
        end
        chk("dd_pulse", found, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dd_dn_off", operation_dn, 0);
        chk("dd_busy", busy, 0);

        // ---- asynchronous reset mid-plane ----
        enable = 1'b1;
        n = 0; found = 0;
        while (n < LIMIT && found == 0) begin
            @(negedge clk); n++;
            if (plane_idx == 3'd2 && led_out) found = 1;
        end
        chk("ar_reach_p2", found, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_led", led_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_plane", plane_idx, 0);
        chk("ar_addr", cur_addr, 0);

        // ---- pointerRegister model, address wrap 125..127,0,1 ----
        @(negedge clk);
        address = 7'd125; pixel_data = BD'(address);
        rst_n = 1'b1; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_a = 7'(125 + k);
            gap = 0; found = 0;
            while (gap < LIMIT && found == 0) begin
                @(negedge clk); gap++;
                if (operation_dn) found = gap;
            end
            chk($sformatf("pt%0d_gap", k), found, PERIOD);
            chk($sformatf("pt%0d_addr", k), cur_addr, exp_a);
            address = address + 7'd1;
            pixel_data = BD'(address);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
